// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdio_pkg
// Clause 22 MDIO frame constants, FSM state type and field-length helper.
// Revision: 1.0
// ============================================================================
package mdio_pkg;

  localparam logic [1:0] c_st    = 2'b01;
  localparam logic [1:0] c_op_wr = 2'b01;
  localparam logic [1:0] c_op_rd = 2'b10;
  localparam logic [1:0] c_ta_wr = 2'b10;

  localparam int c_hdr_len  = 14;
  localparam int c_data_len = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    HDR  = 3'd2,
    TA   = 3'd3,
    DATA = 3'd4
  } state_t;

  // Bit-counter reload value (field length - 1) on entry to a fixed-length field
  function automatic logic [5:0] field_last(input state_t s);
    case (s)
      HDR:     return 6'(c_hdr_len - 1);
      TA:      return 6'd1;
      DATA:    return 6'(c_data_len - 1);
      default: return 6'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_clk_gen.sv
`default_nettype none
// ============================================================================
// Module  : mdio_clk_gen
// MDC generator: CLK_DIV clk cycles per half-period, held low while disabled.
// Revision: 1.0
// ============================================================================
module mdio_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic fall,
  output logic rise
);

  localparam logic [7:0] c_last = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       w_half_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
      mdc   <= 1'b0;
    end else if (!en) begin
      r_cnt <= 8'd0;
      mdc   <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt <= 8'd0;
      mdc   <= ~mdc;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Strobes mark the last cycle of a half; the toggle happens on the following edge
  assign w_half_end = en && (r_cnt == c_last);
  assign fall       = w_half_end && mdc;
  assign rise       = w_half_end && !mdc;

endmodule
`default_nettype wire

// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module  : mdio_master
// Clause 22 MDIO master; define MDIO_RD_TA_CHECK_EN to add the rd_err TA check.
// Revision: 1.0
// ============================================================================
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  phy_add_i,
  input  logic [4:0]  reg_add,
  input  logic [15:0] wr_data,
  input  logic        wren,
  input  logic        rden,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
`ifdef MDIO_RD_TA_CHECK_EN
  output logic        rd_err,
`endif
  input  logic        mdio_i
);

  localparam logic [5:0] c_pre_last = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_bit_cnt;
  logic [31:0] r_shift;
  logic        r_op_wr;
  logic [14:0] r_rd_shift;
  logic        w_en;
  logic        w_fall;
  logic        w_rise_unused;
  logic        w_req;
  logic        w_last_bit;
`ifdef MDIO_RD_TA_CHECK_EN
  logic        r_ta_err;
`endif

  assign w_req      = wren | rden;
  assign w_last_bit = w_fall && (r_bit_cnt == 6'd0);

  mdio_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_en),
    .mdc   (mdc),
    .fall  (w_fall),
    .rise  (w_rise_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req)      w_next = (PREAMBLE_LEN > 0) ? PRE : HDR;
      PRE:     if (w_last_bit) w_next = HDR;
      HDR:     if (w_last_bit) w_next = TA;
      TA:      if (w_last_bit) w_next = DATA;
      DATA:    if (w_last_bit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != IDLE);
    w_en    = busy;
    mdio_oe = 1'b0;
    case (r_state)
      PRE, HDR: mdio_oe = 1'b1;
      TA, DATA: mdio_oe = r_op_wr;
      default:  mdio_oe = 1'b0;
    endcase
    mdio_o = 1'b1;
    if (mdio_oe && (r_state != PRE)) mdio_o = r_shift[31];
  end

  // Shift register only moves on falling-edge strobes, so the pad changes at low-half start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= 6'd0;
      r_shift    <= 32'd0;
      r_op_wr    <= 1'b0;
      r_rd_shift <= 15'd0;
      rd_data    <= 16'd0;
      rd_valid   <= 1'b0;
`ifdef MDIO_RD_TA_CHECK_EN
      r_ta_err   <= 1'b0;
      rd_err     <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
`ifdef MDIO_RD_TA_CHECK_EN
      rd_err   <= 1'b0;
`endif
      if (r_state == IDLE) begin
        if (w_req) begin
          r_op_wr   <= wren;
          r_shift   <= {c_st, (wren ? c_op_wr : c_op_rd), phy_add_i, reg_add, c_ta_wr, wr_data};
          r_bit_cnt <= (PREAMBLE_LEN > 0) ? c_pre_last : field_last(HDR);
`ifdef MDIO_RD_TA_CHECK_EN
          r_ta_err  <= 1'b0;
`endif
        end
      end else if (w_fall) begin
        if (r_state != PRE) r_shift <= {r_shift[30:0], 1'b0};
        if (r_bit_cnt == 6'd0) r_bit_cnt <= field_last(w_next);
        else                   r_bit_cnt <= r_bit_cnt - 6'd1;
`ifdef MDIO_RD_TA_CHECK_EN
        if ((r_state == TA) && !r_op_wr && (r_bit_cnt == 6'd0)) r_ta_err <= mdio_i;
`endif
        if ((r_state == DATA) && !r_op_wr) begin
          r_rd_shift <= {r_rd_shift[13:0], mdio_i};
          if (r_bit_cnt == 6'd0) begin
            rd_valid <= 1'b1;
`ifdef MDIO_RD_TA_CHECK_EN
            rd_err   <= r_ta_err;
            rd_data  <= r_ta_err ? 16'hFFFF : {r_rd_shift, mdio_i};
`else
            rd_data  <= {r_rd_shift, mdio_i};
`endif
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdio_master
// Directed self-checking bench for mdio_master with a simple PHY model.
// Revision: 1.0
// ============================================================================
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  phy_add_i, reg_add;
  logic [15:0] wr_data;
  logic        wren, rden, wren2;
  logic        busy, rd_valid, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rd_data;
  logic        busy2, rd_valid2, mdc2, mdio_o2, mdio_oe2;
  logic [15:0] rd_data2;
`ifdef MDIO_RD_TA_CHECK_EN
  logic        rd_err, rd_err2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .phy_add_i(phy_add_i), .reg_add(reg_add),
    .wr_data(wr_data), .wren(wren), .rden(rden), .busy(busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe),
`ifdef MDIO_RD_TA_CHECK_EN
    .rd_err(rd_err),
`endif
    .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .phy_add_i(phy_add_i), .reg_add(reg_add),
    .wr_data(wr_data), .wren(wren2), .rden(1'b0), .busy(busy2),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .mdc(mdc2), .mdio_o(mdio_o2),
    .mdio_oe(mdio_oe2),
`ifdef MDIO_RD_TA_CHECK_EN
    .rd_err(rd_err2),
`endif
    .mdio_i(1'b1)
  );

  // Wire monitor + PHY at address 0x0F: captures each bit on MDC rise, drives read data there
  int          bitn   = 0;
  int          frames = 0;
  logic        cap_o  [0:63];
  logic        cap_oe [0:63];
  logic        ta_bad = 1'b0;
  logic        rd_me;
  logic [15:0] phy_val;

  always @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      bitn   = 0;
      mdio_i <= 1'b1;
    end else begin
      if (bitn == 64) bitn = 0;
      if (bitn == 0) frames = frames + 1;
      cap_o[bitn]  = mdio_o;
      cap_oe[bitn] = mdio_oe;
      rd_me   = (bitn >= 46) && cap_o[34] && !cap_o[35] &&
                ({cap_o[36], cap_o[37], cap_o[38], cap_o[39], cap_o[40]} == 5'h0F);
      phy_val = ({cap_o[41], cap_o[42], cap_o[43], cap_o[44], cap_o[45]} == 5'h02) ? 16'h796D : 16'h0000;
      if (rd_me && bitn == 47)      mdio_i <= ta_bad;
      else if (rd_me && bitn >= 48) mdio_i <= phy_val[63 - bitn];
      else                          mdio_i <= 1'b1;
      bitn = bitn + 1;
    end
  end

  function automatic logic [63:0] cap_vec(input bit sel_oe);
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[63 - i] = sel_oe ? cap_oe[i] : cap_o[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the strobe is seen by the next posedge (T0)
  task automatic req(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                     input logic w, input logic r);
    phy_add_i = pa; reg_add = ra; wr_data = wd; wren = w; rden = r;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
  endtask

  // Counts busy cycles; returns at the negedge where busy has fallen
  task automatic wait_done(output int cyc, output int rv);
    cyc = 0; rv = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      if (rd_valid) rv++;
      @(negedge clk);
    end
  endtask

  int cyc, rv, n, f0;
  logic [63:0] v_mdc, v_o, v_oe;

  initial begin
    rst_n = 1'b0; wren = 1'b0; rden = 1'b0; wren2 = 1'b0;
    phy_add_i = 5'h0; reg_add = 5'h0; wr_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, rd_valid, mdc, mdio_o, mdio_oe, rd_data}, {5'b00010, 16'h0000});
    rst_n = 1'b1;
    @(negedge clk);

    // Write frame
    req(5'h0F, 5'h00, 16'h1100, 1'b1, 1'b0);
    chk("wr_first_bit", {busy, mdc, mdio_oe, mdio_o}, 4'b1011);
    wait_done(cyc, rv);
    chk("wr_busy_cycles", cyc, 256);
    chk("wr_frame", cap_vec(0), {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h0F, 5'h00, 2'b10, 16'h1100});
    chk("wr_oe", cap_vec(1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_end_pins", {mdc, mdio_oe, mdio_o, rd_valid, rv[0]}, 5'b00100);
    @(negedge clk);

    // Read frame from the PHY model
    req(5'h0F, 5'h02, 16'h0000, 1'b0, 1'b1);
    wait_done(cyc, rv);
    chk("rd_busy_cycles", cyc, 256);
    chk("rd_end", {rd_valid, mdc, mdio_oe, rd_data}, {3'b100, 16'h796D});
    chk("rd_frame", cap_vec(0), {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h0F, 5'h02, 18'h3FFFF});
    chk("rd_oe", cap_vec(1), 64'hFFFF_FFFF_FFFC_0000);

    // Collision issued in the cycle busy falls: back-to-back write-only frame
    f0 = frames;
    req(5'h0F, 5'h03, 16'hBEEF, 1'b1, 1'b1);
    chk("b2b_start", {busy, rd_valid, rd_data}, {2'b10, 16'h796D});
    rden = 1'b1;            // stray strobe while busy, one cycle of the frame
    @(negedge clk);
    rden = 1'b0;
    wait_done(cyc, rv);
    chk("col_busy_cycles", cyc + 1, 256);
    chk("col_no_rd_valid", rv + int'(rd_valid), 0);
    chk("col_frame", cap_vec(0), {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h0F, 5'h03, 2'b10, 16'hBEEF});
    repeat (40) @(negedge clk);
    chk("ignored_strobe", {busy, 32'(frames - f0)}, {1'b0, 32'd1});

    // Reset during HDR bit 5 of a read
    req(5'h0F, 5'h02, 16'h0000, 1'b0, 1'b1);
    n = 0;
    while (bitn != 38 && n < 2000) begin @(negedge clk); n++; end
    chk("hdr5_reached", {mdc, 1'(n < 2000)}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {mdc, busy, mdio_oe, mdio_o, rd_data}, {4'b0001, 16'h0000});
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    repeat (300) begin @(negedge clk); if (rd_valid || busy) rv++; end
    chk("post_reset_quiet", rv, 0);
    req(5'h0F, 5'h05, 16'h1234, 1'b1, 1'b0);
    wait_done(cyc, rv);
    chk("post_reset_cycles", cyc, 256);
    chk("post_reset_frame", cap_vec(0), {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h0F, 5'h05, 2'b10, 16'h1234});
    @(negedge clk);

    // No preamble, CLK_DIV=1 instance
    phy_add_i = 5'h01; reg_add = 5'h1F; wr_data = 16'hA5F0; wren2 = 1'b1;
    @(negedge clk);
    wren2 = 1'b0;
    cyc = 0; v_mdc = '0; v_o = '0; v_oe = '0;
    while (busy2 && cyc < 200) begin
      v_mdc = {v_mdc[62:0], mdc2};
      v_o   = {v_o[62:0], mdio_o2};
      v_oe  = {v_oe[62:0], mdio_oe2};
      cyc++;
      @(negedge clk);
    end
    chk("p0_busy_cycles", cyc, 64);
    chk("p0_mdc_toggle", v_mdc, 64'h5555_5555_5555_5555);
    chk("p0_st_first", v_o[63:56], 8'b0011_0011);
    chk("p0_oe", v_oe, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p0_end", {mdc2, mdio_oe2, rd_valid2}, 3'b000);

`ifdef MDIO_RD_TA_CHECK_EN
    ta_bad = 1'b1;
    req(5'h0F, 5'h02, 16'h0000, 1'b0, 1'b1);
    wait_done(cyc, rv);
    chk("ta_bad", {rd_valid, rd_err, rd_data}, {2'b11, 16'hFFFF});
    @(negedge clk);
    chk("ta_err_pulse", {rd_valid, rd_err}, 2'b00);
    ta_bad = 1'b0;
    req(5'h0F, 5'h02, 16'h0000, 1'b0, 1'b1);
    wait_done(cyc, rv);
    chk("ta_good", {rd_valid, rd_err, rd_data}, {2'b10, 16'h796D});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause 22 MDIO management master; consumes the single-cycle register-access requests issued by the PHY configuration sequencer (phy address, register address, write data, wren/rden, busy).
- Serializes each request onto MDC/MDIO toward the external PHY (ADIN1300).
- For reads, returns the 16-bit register value with a one-cycle valid strobe.
- Sits between the config sequencer and the top-level MDIO pad (tristate split into o/oe/i).

Parameters:
- CLK_DIV, 10, clk cycles per MDC half-period; legal range 1..255; MDC frequency = f_clk/(2*CLK_DIV).
- PREAMBLE_LEN, 32, number of preamble '1' bits; legal range 0..32.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- phy_add_i  in  5  target PHY address
- reg_add  in  5  target register address
- wr_data  in  16  write payload
- wren  in  1  write request strobe
- rden  in  1  read request strobe
- busy  out  1  transaction in progress; requests ignored while high
- rd_data  out  16  read result; holds until next read completes
- rd_valid  out  1  one-cycle pulse when rd_data is updated
- mdc  out  1  management clock
- mdio_o  out  1  MDIO output data
- mdio_oe  out  1  MDIO output enable (1 = drive)
- mdio_i  in  1  MDIO pad input

Behaviour:
- Reset (async, any time, including mid-frame):
  - busy=0, rd_valid=0, rd_data=0, mdc=0, mdio_o=1, mdio_oe=0.
  - State returns to IDLE and counters clear.
  - No partial rd_valid is produced.
- Accept:
  - In IDLE with busy=0, a cycle with wren or rden high latches phy_add_i, reg_add and wr_data, plus an op flag.
  - If wren and rden are both high, the write wins; the read is dropped.
  - Strobes arriving while busy=1 are ignored.
- Frame bit order, MSB first:
  - PREAMBLE_LEN x '1'.
  - ST=01.
  - OP=01 for write, 10 for read.
  - PHYAD[4:0], REGAD[4:0].
  - TA: write drives 1,0; read sets mdio_oe=0 for both TA bits.
  - DATA[15:0]: write drives wr_data; read keeps oe=0 and samples.
  - Total bits N = PREAMBLE_LEN+32.
- Bit timing:
  - Each bit is a low half (CLK_DIV cycles, mdc=0) followed by a high half (CLK_DIV cycles, mdc=1).
  - mdio_o/mdio_oe change only at the start of a low half, i.e. at the falling edge or frame start.
  - Read data is sampled from mdio_i in the clk cycle mdc goes 1→0, so the PHY has a full high half after its rising-edge drive.
- Latency:
  - Accept at cycle T0; busy=1 and the first bit is on the wire from T0+1.
  - busy=1 for exactly 2*CLK_DIV*N cycles.
  - In the cycle busy falls: mdc=0, mdio_oe=0; for reads, rd_valid=1 and rd_data is updated in that same cycle.
  - A new request is accepted in the cycle busy is low, giving back-to-back frames.
- States:
  - IDLE → PRE (skipped if PREAMBLE_LEN=0) → HDR (14 bits: ST, OP, PHYAD, REGAD) → TA (2 bits) → DATA (16 bits) → IDLE.
  - A 6-bit bit counter and an 8-bit divider counter are used.
  - Transitions occur at the end of the high half of a field's last bit.
- mdio_o is held at 1 when mdio_oe=0 and in IDLE.

Optional Feature:
- Macro MDIO_RD_TA_CHECK_EN.
- Defined:
  - Adds output port rd_err (1 bit).
  - On reads, mdio_i is sampled during the second TA bit (same sampling point as data bits); a PHY must drive 0 there.
  - If the sample is 1, the data bits are still clocked, but at completion rd_data=16'hFFFF and rd_err=1, pulsed together with rd_valid.
  - rd_err resets to 0.
- Undefined:
  - No rd_err port; TA is not sampled; rd_data is always the sampled value.

Decomposition:
- Package mdio_pkg:
  - ST constant 2'b01, OP_WR 2'b01, OP_RD 2'b10, TA_WR 2'b10.
  - Header length 14, data length 16.
  - State enum IDLE/PRE/HDR/TA/DATA.
- Sub-module mdio_clk_gen (parameter CLK_DIV):
  - Runs only while enabled; outputs mdc, a fall strobe (start of low half) and a rise strobe.
  - Forced low and counter cleared when disabled or in reset.

Test Plan:
- Write: CLK_DIV=2, PREAMBLE_LEN=32, phy_add_i=5'h0F, reg_add=0, wr_data=16'h1100 → monitor captures 32×'1', 01 01 01111 00000 10 0001000100000000; busy high for exactly 256 cycles; mdio_oe=1 throughout.
- Read: PHY model at address 0x0F returning 16'h796D on reg 5'h02 → mdio_oe=0 from TA through DATA; rd_valid single pulse with rd_data=16'h796D in the cycle busy falls.
- Collision and ignore: wren=rden=1 in the same cycle → write frame only (OP=01), no rd_valid. A strobe while busy → no second frame; a strobe in the cycle busy falls → second frame starts the next cycle.
- Reset mid-frame: assert rst_n=0 during HDR bit 5 → mdc, busy, mdio_oe drop to 0 asynchronously. After release: no rd_valid, and a new request yields a clean full frame.
- PREAMBLE_LEN=0 and CLK_DIV=1 → 32-bit frame starting with ST, mdc toggling every clk, busy high for 64 cycles.
- With MDIO_RD_TA_CHECK_EN: the PHY model drives 1 in TA bit 2 → rd_valid=1, rd_err=1, rd_data=16'hFFFF. A compliant PHY → rd_err=0.
